// File: rtl/cg_if_pkg.sv
// Shared types for the instruction-fetch stage.
//   if_state_e     fetch sequencer state
//   fetch_entry_t  one prefetch-buffer entry at core-wide widths
//   entry_width    total bit width of a {pc, instr} buffer entry
package cg_if_pkg;

  localparam int CORE_ADDR_WIDTH  = 32;
  localparam int CORE_INSTR_WIDTH = 32;

  typedef enum logic [1:0] {
    IF_IDLE,
    IF_RUN,
    IF_HALT
  } if_state_e;

  typedef struct packed {
    logic [CORE_ADDR_WIDTH-1:0]  pc;
    logic [CORE_INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

  function automatic int entry_width(int addr_w, int instr_w);
    return addr_w + instr_w;
  endfunction

endpackage

// File: rtl/cg_fetch_fifo.sv
// Synchronous prefetch FIFO.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   flush        empties the buffer; wins over push and pop
//   push, din    write an entry (ignored when full unless popping the same cycle)
//   pop          remove the head (ignored when empty)
//   dout         head entry, zero when empty
//   count        number of stored entries
//   empty, full  status flags
module cg_fetch_fifo
  import cg_if_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 64,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty & ~flush;
  // A full buffer may still accept a write when the head leaves in the same cycle.
  assign do_push = push & ~flush & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/cg_stage_if_pf.sv
// Instruction-fetch stage with prefetch buffer.
// Issues sequential word reads, tracks in-flight requests against buffer credits,
// tags returned words with their PC and presents them to decode over valid/ready.
// A redirect flushes the buffer and marks every in-flight response for discard.
// Ports:
//   i_clk, i_rst               clock, asynchronous active-high reset
//   i_prst, i_new_pc           redirect request and target word address
//   i_halt                     stop issuing new reads
//   o_imem_ren, o_imem_raddr   read request / word address
//   i_imem_gnt                 request accepted this cycle
//   i_imem_rdata_valid/_rdata  in-order read response
//   o_instr_valid/_instr/_pc   buffer head to decode
//   i_instr_ready              decode takes head when valid & ready
//
// state   | meaning
// IF_IDLE | just out of reset, nothing issued yet
// IF_RUN  | issuing reads while credits allow
// IF_HALT | issue stopped, in-flight reads still collected
module cg_stage_if_pf
  import cg_if_pkg::*;
#(
  parameter int                   DATA_WIDTH      = 32,
  parameter int                   ADDR_WIDTH      = 32,
  parameter int                   INSTR_WIDTH     = 32,
  parameter int                   FIFO_DEPTH      = 4,
  parameter int                   MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_prst,
  input  logic [ADDR_WIDTH-1:0]  i_new_pc,
  input  logic                   i_halt,
  output logic                   o_imem_ren,
  output logic [ADDR_WIDTH-1:0]  o_imem_raddr,
  input  logic                   i_imem_gnt,
  input  logic                   i_imem_rdata_valid,
  input  logic [DATA_WIDTH-1:0]  i_imem_rdata,
  output logic                   o_instr_valid,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0]  o_instr_pc,
  input  logic                   i_instr_ready
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = entry_width(ADDR_WIDTH, INSTR_WIDTH);

  if_state_e             state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] resp_pc;
  logic [OW-1:0]         outstanding;
  logic [OW-1:0]         drop;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [EW-1:0]         head;
  logic                  credit_ok;
  logic                  issue;
  logic                  rsp;
  logic                  push;
  logic                  pop;
  logic                  unused_ok;

  // Every in-flight read owns a buffer slot, so the buffer can never overflow.
  assign credit_ok = (int'(fifo_count) + int'(outstanding) < FIFO_DEPTH) &&
                     (int'(outstanding) < MAX_OUTSTANDING);

  assign o_imem_ren   = (state == IF_RUN) & ~i_prst & credit_ok;
  assign o_imem_raddr = pc;

  assign issue = o_imem_ren & i_imem_gnt;
  assign rsp   = i_imem_rdata_valid;
  assign push  = rsp & (drop == '0) & ~i_prst;
  assign pop   = o_instr_valid & i_instr_ready;

  assign o_instr_valid           = ~fifo_empty;
  assign {o_instr_pc, o_instr}   = head;
  assign unused_ok               = fifo_full;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IF_IDLE;
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      case (state)
        IF_IDLE: if (!i_prst) state <= IF_RUN;
        IF_RUN:  if (i_halt)  state <= IF_HALT;
        IF_HALT: if (!i_halt) state <= IF_RUN;
        default: state <= IF_IDLE;
      endcase

      if (i_prst) begin
        pc          <= i_new_pc;
        resp_pc     <= i_new_pc;
        // No issue happens during a redirect, so everything still in flight is stale.
        outstanding <= outstanding - OW'(rsp);
        drop        <= outstanding - OW'(rsp);
      end else begin
        if (issue) pc <= pc + ADDR_WIDTH'(1);
        outstanding <= outstanding + OW'(issue) - OW'(rsp);
        if (rsp) begin
          if (drop != '0) drop    <= drop - OW'(1);
          else            resp_pc <= resp_pc + ADDR_WIDTH'(1);
        end
      end
    end
  end

  cg_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .flush (i_prst),
    .push  (push),
    .pop   (pop),
    .din   ({resp_pc, i_imem_rdata[INSTR_WIDTH-1:0]}),
    .dout  (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_cg_stage_if_pf.sv
module tb_cg_stage_if_pf;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_prst;
  logic [31:0] i_new_pc;
  logic        i_halt;
  logic        o_imem_ren;
  logic [31:0] o_imem_raddr;
  logic        i_imem_gnt;
  logic        i_imem_rdata_valid;
  logic [31:0] i_imem_rdata;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        i_instr_ready;

  always #5 i_clk = ~i_clk;

  cg_stage_if_pf dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_prst             (i_prst),
    .i_new_pc           (i_new_pc),
    .i_halt             (i_halt),
    .o_imem_ren         (o_imem_ren),
    .o_imem_raddr       (o_imem_raddr),
    .i_imem_gnt         (i_imem_gnt),
    .i_imem_rdata_valid (i_imem_rdata_valid),
    .i_imem_rdata       (i_imem_rdata),
    .o_instr_valid      (o_instr_valid),
    .o_instr            (o_instr),
    .o_instr_pc         (o_instr_pc),
    .i_instr_ready      (i_instr_ready)
  );

  typedef struct {
    int unsigned due;
    logic [31:0] addr;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int unsigned cyc;
  } cap_t;

  req_t        pend[$];
  cap_t        got[$];
  int unsigned cyc      = 0;
  int unsigned lat      = 1;
  int unsigned n_issued = 0;
  int unsigned max_pend = 0;
  int          n_vec    = 0;
  int          n_bad    = 0;
  logic        s_iss;
  logic        s_rsp;
  logic [31:0] s_addr;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    case (a)
      32'd0:   return 32'h0000_0114;
      32'd1:   return 32'h0000_0214;
      32'd2:   return 32'hAAAA_AAAA;
      default: return 32'hC0DE_0000 ^ a;
    endcase
  endfunction

  function automatic cap_t get_cap(int i);
    cap_t c;
    c = '{32'hDEAD_DEAD, 32'hDEAD_DEAD, 0};
    if (i >= 0 && i < got.size()) c = got[i];
    return c;
  endfunction

  // Memory: requests sampled mid-cycle, in-order responses driven just after the edge.
  always begin
    @(negedge i_clk);
    s_iss  = !i_rst && o_imem_ren && i_imem_gnt;
    s_addr = o_imem_raddr;
    s_rsp  = !i_rst && i_imem_rdata_valid;
    @(posedge i_clk);
    #1;
    cyc++;
    if (i_rst) begin
      pend.delete();
    end else begin
      if (s_rsp && pend.size() > 0) pend.delete(0);
      if (s_iss) begin
        pend.push_back('{cyc + lat - 1, s_addr});
        n_issued++;
      end
      if (pend.size() > max_pend) max_pend = pend.size();
    end
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      i_imem_rdata_valid = 1'b1;
      i_imem_rdata       = mem_word(pend[0].addr);
    end else begin
      i_imem_rdata_valid = 1'b0;
      i_imem_rdata       = '0;
    end
  end

  always @(negedge i_clk) begin
    if (!i_rst && !i_prst && o_instr_valid && i_instr_ready)
      got.push_back('{o_instr_pc, o_instr, cyc});
  end

  task automatic check_val(string tag, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge i_clk);
    #2;
  endtask

  task automatic do_reset();
    i_rst  = 1'b1;
    i_prst = 1'b0;
    i_halt = 1'b0;
    tick(2);
    got.delete();
    max_pend = 0;
    n_issued = 0;
    i_rst    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned c0;
    int          idx;
    logic        found;

    i_rst = 1'b0; i_prst = 1'b0; i_new_pc = '0; i_halt = 1'b0;
    i_imem_gnt = 1'b0; i_instr_ready = 1'b0;
    i_imem_rdata_valid = 1'b0; i_imem_rdata = '0;
    #1 i_rst = 1'b1;

    // reset values
    @(negedge i_clk);
    check_val("rst_ren",   o_imem_ren,    0);
    check_val("rst_raddr", o_imem_raddr,  0);
    check_val("rst_valid", o_instr_valid, 0);
    check_val("rst_instr", o_instr,       0);
    check_val("rst_pc",    o_instr_pc,    0);

    // 1: streaming, 1-cycle memory
    lat = 1; i_imem_gnt = 1'b1; i_instr_ready = 1'b1;
    do_reset();
    c0 = cyc;
    tick(12);
    for (int i = 0; i < 6; i++) begin
      check_val($sformatf("t1_pc%0d", i),    get_cap(i).pc,    i);
      check_val($sformatf("t1_instr%0d", i), get_cap(i).instr, mem_word(i));
      check_val($sformatf("t1_cyc%0d", i),   get_cap(i).cyc,   c0 + 3 + i);
    end

    // 2: decode stalled, buffer fills to depth then drains in order
    i_instr_ready = 1'b0;
    do_reset();
    tick(10);
    check_val("t2_none_out", got.size(), 0);
    check_val("t2_issued",   n_issued,   4);
    @(negedge i_clk);
    check_val("t2_ren",   o_imem_ren,    0);
    check_val("t2_valid", o_instr_valid, 1);
    check_val("t2_head",  o_instr_pc,    0);
    tick(1);
    i_instr_ready = 1'b1;
    tick(12);
    check_val("t2_maxpend", max_pend <= 2, 1);
    for (int i = 0; i < 6; i++)
      check_val($sformatf("t2_pc%0d", i), get_cap(i).pc, i);

    // 3: redirect with two reads in flight on a 3-cycle memory
    lat = 3;
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (pend.size() == 2 && !i_imem_rdata_valid) found = 1'b1;
      else tick(1);
    end
    check_val("t3_inflight", found, 1);
    idx = got.size();
    i_prst = 1'b1; i_new_pc = 32'h40;
    tick(1);
    i_prst = 1'b0;
    tick(20);
    check_val("t3_pc0",    get_cap(idx).pc,        32'h40);
    check_val("t3_instr0", get_cap(idx).instr,     mem_word(32'h40));
    check_val("t3_pc1",    get_cap(idx + 1).pc,    32'h41);
    check_val("t3_instr1", get_cap(idx + 1).instr, mem_word(32'h41));
    check_val("t3_maxpend", max_pend <= 2, 1);

    // 4: redirect coinciding with a response and a pop
    lat = 1;
    do_reset();
    tick(6);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (i_imem_rdata_valid && o_instr_valid) found = 1'b1;
      else tick(1);
    end
    check_val("t4_busy", found, 1);
    idx = got.size();
    c0  = cyc;
    i_prst = 1'b1; i_new_pc = 32'h80;
    tick(1);
    i_prst = 1'b0;
    tick(10);
    check_val("t4_pc0",    get_cap(idx).pc,     32'h80);
    check_val("t4_instr0", get_cap(idx).instr,  mem_word(32'h80));
    check_val("t4_cyc0",   get_cap(idx).cyc,    c0 + 3);
    check_val("t4_pc1",    get_cap(idx + 1).pc, 32'h81);

    // 5: grant withheld, then halt
    i_imem_gnt = 1'b0;
    do_reset();
    tick(2);
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      check_val($sformatf("t5_ren%0d", i),   o_imem_ren,   1);
      check_val($sformatf("t5_raddr%0d", i), o_imem_raddr, 0);
    end
    tick(1);
    check_val("t5_nothing", got.size(), 0);
    i_imem_gnt = 1'b1;
    tick(6);
    i_halt = 1'b1;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      check_val($sformatf("t5_halt_ren%0d", i), o_imem_ren, 0);
    end
    tick(1);
    check_val("t5_some",      n_issued >= 5, 1);
    check_val("t5_delivered", got.size(), n_issued);
    check_val("t5_lastpc",    get_cap(got.size() - 1).pc, n_issued - 1);
    i_halt = 1'b0;

    // 6: asynchronous reset mid-stream
    do_reset();
    tick(8);
    check_val("t6_pre_valid", o_instr_valid, 1);
    #1 i_rst = 1'b1;
    #1;
    check_val("t6_valid", o_instr_valid, 0);
    check_val("t6_ren",   o_imem_ren,    0);
    check_val("t6_raddr", o_imem_raddr,  0);
    check_val("t6_instr", o_instr,       0);
    check_val("t6_pc",    o_instr_pc,    0);
    tick(1);
    got.delete();
    n_issued = 0;
    c0 = cyc;
    i_rst = 1'b0;
    tick(8);
    check_val("t6_re_pc",    get_cap(0).pc,    0);
    check_val("t6_re_instr", get_cap(0).instr, 32'h114);
    check_val("t6_re_cyc",   get_cap(0).cyc,   c0 + 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
